multdiv_ctrl: RTL

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_addsub.sv | 13 +
 rtl/multdiv_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding, default width and counter sizing for multdiv_ctrl
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// rtl/multdiv_addsub.sv - (WIDTH+1)-bit adder/subtractor shared by the multiply and divide steps
module multdiv_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    input  logic           i_sub,
    output logic [WIDTH:0] o_sum
);

    assign o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - iterative signed multiply (radix-2 Booth) / restoring divide, one step per cycle
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             stall
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH:0]    r_acc;      // MUL: high half of product, DIV: partial remainder
    logic [WIDTH-1:0]  r_lo;       // MUL: multiplier/low product, DIV: dividend/quotient
    logic              r_q1;
    logic [WIDTH-1:0]  r_opa;      // MUL: multiplicand, DIV: divisor magnitude
    logic              r_neg;
    logic              r_dz;
    logic              r_ovf;
    logic [WIDTH-1:0]  r_result;
    logic              r_exc;
    logic              r_rdy;
    logic              r_stall;

    logic              w_start;
    logic              w_last;
    logic [WIDTH:0]    w_as_a, w_as_b, w_sum;
    logic              w_as_sub;
    logic [WIDTH:0]    w_mul_sum, w_acc_mul_nxt, w_div_shift, w_acc_div_nxt;
    logic [WIDTH-1:0]  w_lo_mul_nxt, w_lo_div_nxt, w_quot;
    logic              w_div_ok;
    logic [WIDTH-1:0]  w_abs_a, w_abs_b;
    logic [WIDTH-1:0]  w_result_nxt;
    logic              w_exc_nxt, w_rdy_nxt, w_stall_nxt;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    always_comb begin
        w_as_a   = r_acc;
        w_as_b   = {r_opa[WIDTH-1], r_opa};
        w_as_sub = r_lo[0] & ~r_q1;
        if (r_state == ST_DIV) begin
            w_as_a   = w_div_shift;
            w_as_b   = {1'b0, r_opa};
            w_as_sub = 1'b1;
        end
    end

    multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a   (w_as_a),
        .i_b   (w_as_b),
        .i_sub (w_as_sub),
        .o_sum (w_sum)
    );

    // Booth step: add/subtract on a 01/10 bit pair, then arithmetic shift right of {acc, lo}
    assign w_mul_sum     = (r_lo[0] ^ r_q1) ? w_sum : r_acc;
    assign w_acc_mul_nxt = {w_mul_sum[WIDTH], w_mul_sum[WIDTH:1]};
    assign w_lo_mul_nxt  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    assign w_div_shift   = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_div_ok      = ~w_sum[WIDTH];
    assign w_acc_div_nxt = w_div_ok ? w_sum : w_div_shift;
    assign w_lo_div_nxt  = {r_lo[WIDTH-2:0], w_div_ok};
    assign w_quot        = r_neg ? (~w_lo_div_nxt + 1'b1) : w_lo_div_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ctrl_MULT ? ST_MUL : ST_DIV;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_MUL:  if (w_last) w_state_nxt = ST_DONE;
                ST_DIV:  if (r_dz || w_last) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; divide-by-zero answers on the start edge itself
    always_comb begin
        w_result_nxt = r_result;
        w_exc_nxt    = r_exc;
        w_rdy_nxt    = 1'b0;
        w_stall_nxt  = r_stall;
        if (w_start) begin
            if (!ctrl_MULT && (data_operandB == '0)) begin
                w_result_nxt = '0;
                w_exc_nxt    = 1'b1;
                w_rdy_nxt    = 1'b1;
                w_stall_nxt  = 1'b0;
            end else begin
                w_stall_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                ST_MUL: if (w_last) begin
                    w_result_nxt = w_lo_mul_nxt;
                    w_exc_nxt    = (w_acc_mul_nxt[WIDTH-1:0] != {WIDTH{w_lo_mul_nxt[WIDTH-1]}});
                    w_rdy_nxt    = 1'b1;
                    w_stall_nxt  = 1'b0;
                end
                ST_DIV: if (!r_dz && w_last) begin
                    w_result_nxt = w_quot;
                    w_exc_nxt    = r_ovf;
                    w_rdy_nxt    = 1'b1;
                    w_stall_nxt  = 1'b0;
                end
                default: w_stall_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_q1     <= 1'b0;
            r_opa    <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_stall  <= 1'b0;
        end else begin
            r_result <= w_result_nxt;
            r_exc    <= w_exc_nxt;
            r_rdy    <= w_rdy_nxt;
            r_stall  <= w_stall_nxt;
            if (w_start) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_q1  <= 1'b0;
                if (ctrl_MULT) begin
                    r_lo  <= data_operandB;
                    r_opa <= data_operandA;
                    r_neg <= 1'b0;
                    r_dz  <= 1'b0;
                    r_ovf <= 1'b0;
                end else begin
                    r_lo  <= w_abs_a;
                    r_opa <= w_abs_b;
                    r_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    r_dz  <= (data_operandB == '0);
                    r_ovf <= (data_operandA == MOST_NEG) && (data_operandB == '1);
                end
            end else if (r_state == ST_MUL) begin
                r_acc <= w_acc_mul_nxt;
                r_lo  <= w_lo_mul_nxt;
                r_q1  <= r_lo[0];
                r_cnt <= r_cnt + 1'b1;
            end else if ((r_state == ST_DIV) && !r_dz) begin
                r_acc <= w_acc_div_nxt;
                r_lo  <= w_lo_div_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign stall          = r_stall;

endmodule
